// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types, sizes and address checks for the MIPS memory responder
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int MEM_AW         = 8;
  localparam int RELEASE_CYCLES = 2;
  localparam int ADDR_W         = 32;
  localparam int WORD_LSB       = 2;

  // A byte address is usable when word aligned and inside the 2^aw word window.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int aw);
    logic [ADDR_W-1:0] hi;
    hi = addr >> (aw + WORD_LSB);
    return (addr[WORD_LSB-1:0] == '0) && (hi == '0);
  endfunction

endpackage

// File: rtl/mips_mem_responder_mem_array.sv
// rtl/mips_mem_responder_mem_array.sv - word storage with two async read ports and one sync write port
module mem_array #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [2**AW];

  // No reset on the array: loaded program must survive a CPU reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - host-loaded instruction/data memory that holds the CPU in reset until loaded
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int MEM_AW         = mips_mem_pkg::MEM_AW,
  parameter int RELEASE_CYCLES = mips_mem_pkg::RELEASE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC,
  output logic [31:0]       Instruction,
  input  logic [31:0]       Address,
  input  logic              MemWrite,
  input  logic [31:0]       Write_data,
  input  logic              MemRead,
  output logic [31:0]       Read_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              cpu_rst,
  output logic [MEM_AW:0]   ld_count,
  output logic              err
);

  localparam int CNT_W = (RELEASE_CYCLES < 1) ? 1 : $clog2(RELEASE_CYCLES + 1);

  logic [1:0]        sync_q;
  state_e            state_q;
  logic              ld_ready_q;
  logic              cpu_rst_q;
  logic              err_q;
  logic [MEM_AW:0]   count_q;
  logic [CNT_W-1:0]  rel_cnt_q;

  logic              run_en;
  logic              in_run;
  logic              xfer;
  logic              pc_ok;
  logic              da_ok;
  logic              access_err;
  logic              rel_done;

  logic              we;
  logic [MEM_AW-1:0] waddr;
  logic [31:0]       wdata;
  logic [31:0]       rdata_a;
  logic [31:0]       rdata_b;

  // Reset asserts asynchronously but only releases the FSM two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run_en     = sync_q[1];
  assign in_run     = (state_q == ST_RUN);
  assign xfer       = ld_valid && ld_ready_q && run_en && (state_q == ST_LOAD);
  assign pc_ok      = addr_ok(PC, MEM_AW);
  assign da_ok      = addr_ok(Address, MEM_AW);
  assign access_err = in_run && (!pc_ok || ((MemRead || MemWrite) && !da_ok) ||
                                 (MemRead && MemWrite));
  assign rel_done   = (int'(rel_cnt_q) + 1) >= RELEASE_CYCLES;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      ld_ready_q <= 1'b1;
      cpu_rst_q  <= 1'b1;
      err_q      <= 1'b0;
      count_q    <= '0;
      rel_cnt_q  <= '0;
    end else begin
      if (access_err) begin
        err_q <= 1'b1;
      end
      if (xfer && !count_q[MEM_AW]) begin
        count_q <= count_q + 1'b1;
      end
      case (state_q)
        ST_LOAD: begin
          if (xfer && ld_last) begin
            state_q    <= ST_RELEASE;
            ld_ready_q <= 1'b0;
            rel_cnt_q  <= '0;
          end
        end
        ST_RELEASE: begin
          if (rel_done) begin
            state_q   <= ST_RUN;
            cpu_rst_q <= 1'b0;
          end else begin
            rel_cnt_q <= rel_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  // Host owns the write port while loading, the CPU while running, nobody in between.
  always_comb begin
    we    = 1'b0;
    waddr = ld_addr;
    wdata = ld_data;
    case (state_q)
      ST_LOAD: begin
        we = xfer;
      end
      ST_RUN: begin
        we    = MemWrite && da_ok;
        waddr = Address[MEM_AW+1:2];
        wdata = Write_data;
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

  mem_array #(
    .AW (MEM_AW),
    .DW (32)
  ) u_mem (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (PC[MEM_AW+1:2]),
    .rdata_a_o (rdata_a),
    .raddr_b_i (Address[MEM_AW+1:2]),
    .rdata_b_o (rdata_b)
  );

  assign Instruction = (in_run && pc_ok) ? rdata_a : 32'd0;
  assign Read_data   = (in_run && MemRead && da_ok) ? rdata_b : 32'd0;
  assign ld_ready    = ld_ready_q;
  assign cpu_rst     = cpu_rst_q;
  assign ld_count    = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - directed self-checking bench for the MIPS memory responder
module tb_mips_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic        MemRead;
  logic [31:0] Read_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        cpu_rst;
  logic [8:0]  ld_count;
  logic        err;

  int passed;
  int total;

  mips_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (PC),
    .Instruction (Instruction),
    .Address     (Address),
    .MemWrite    (MemWrite),
    .Write_data  (Write_data),
    .MemRead     (MemRead),
    .Read_data   (Read_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .cpu_rst     (cpu_rst),
    .ld_count    (ld_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic reload_last_only(input logic [7:0] a, input logic [31:0] d);
    do_reset();
    load_word(a, d, 1'b1);
    tick();
    tick();
    chk("reload_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b0;
    PC         = 32'd0;
    Address    = 32'd0;
    MemWrite   = 1'b0;
    Write_data = 32'd0;
    MemRead    = 1'b0;
    ld_valid   = 1'b0;
    ld_addr    = 8'd0;
    ld_data    = 32'd0;
    ld_last    = 1'b0;
    tick();
    tick();
    #2;
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_ld_count", {23'd0, ld_count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    tick();

    // 256 words without last saturate the counter and stay in LOAD
    for (int i = 0; i < 256; i++) begin
      load_word(i[7:0], 32'hA500_0000 | i, 1'b0);
    end
    chk("sat_count_256", {23'd0, ld_count}, 32'd256);
    load_word(8'd0, 32'hA500_0000, 1'b0);
    chk("sat_count_hold", {23'd0, ld_count}, 32'd256);
    chk("sat_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("sat_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // Program load; a CPU store to idx3 during LOAD must be ignored
    do_reset();
    PC         = 32'h4;
    Address    = 32'hC;
    MemWrite   = 1'b1;
    MemRead    = 1'b1;
    Write_data = 32'h1111_1111;
    ld_valid   = 1'b1;
    ld_addr    = 8'd0;
    ld_data    = 32'h2401_0005;
    #1;
    chk("load_instr_zero", Instruction, 32'd0);
    chk("load_rdata_zero", Read_data, 32'd0);
    load_word(8'd0, 32'h2401_0005, 1'b0);
    load_word(8'd1, 32'h8C02_0010, 1'b0);
    load_word(8'd2, 32'hAC02_0014, 1'b1);
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    chk("load_count_3", {23'd0, ld_count}, 32'd3);
    chk("last_ld_ready_drop", {31'd0, ld_ready}, 32'd0);
    chk("release_cyc1", {31'd0, cpu_rst}, 32'd1);
    tick();
    chk("release_cyc2", {31'd0, cpu_rst}, 32'd1);
    tick();
    chk("run_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
    chk("run_ld_ready_low", {31'd0, ld_ready}, 32'd0);

    PC = 32'h4;
    #1;
    chk("fetch_pc4", Instruction, 32'h8C02_0010);
    MemRead = 1'b1;
    Address = 32'hC;
    #1;
    chk("load_store_ignored", Read_data, 32'hA500_0003);
    tick();
    chk("err_clean", {31'd0, err}, 32'd0);
    MemRead = 1'b0;
    PC = 32'h400;
    #1;
    chk("fetch_out_of_range", Instruction, 32'd0);
    PC = 32'h2;
    #1;
    chk("fetch_misaligned", Instruction, 32'd0);
    tick();
    chk("err_bad_pc", {31'd0, err}, 32'd1);
    PC = 32'h0;

    // Store with simultaneous load returns old data, then new data
    reload_last_only(8'd2, 32'hAC02_0014);
    chk("err_cleared_by_reset", {31'd0, err}, 32'd0);
    Address    = 32'h14;
    Write_data = 32'hDEAD_BEEF;
    MemWrite   = 1'b1;
    MemRead    = 1'b1;
    #1;
    chk("rw_old_data", Read_data, 32'hA500_0005);
    tick();
    MemWrite = 1'b0;
    #1;
    chk("rw_new_data", Read_data, 32'hDEAD_BEEF);
    chk("err_rw_both", {31'd0, err}, 32'd1);
    MemRead = 1'b0;

    // Out-of-range store is suppressed and flagged
    reload_last_only(8'd2, 32'hAC02_0014);
    Address    = 32'h400;
    Write_data = 32'h1234_5678;
    MemWrite   = 1'b1;
    tick();
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    #1;
    chk("err_bad_store", {31'd0, err}, 32'd1);
    chk("read_out_of_range", Read_data, 32'd0);
    Address = 32'h0;
    #1;
    chk("no_alias_write", Read_data, 32'h2401_0005);
    Address = 32'h15;
    #1;
    chk("read_misaligned", Read_data, 32'd0);
    MemRead = 1'b0;
    Address = 32'h0;
    tick();

    // Reset mid-RUN takes effect immediately and keeps memory
    #2 rst = 1'b0;
    #1;
    chk("midrun_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("midrun_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("midrun_ld_count", {23'd0, ld_count}, 32'd0);
    chk("midrun_err", {31'd0, err}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    load_word(8'd9, 32'h0000_0009, 1'b1);
    chk("midrun_reload_count", {23'd0, ld_count}, 32'd1);
    tick();
    tick();
    chk("midrun_run_again", {31'd0, cpu_rst}, 32'd0);
    PC = 32'h4;
    #1;
    chk("keep_idx1", Instruction, 32'h8C02_0010);
    PC = 32'h14;
    #1;
    chk("keep_store", Instruction, 32'hDEAD_BEEF);
    PC = 32'h24;
    #1;
    chk("reload_idx9", Instruction, 32'h0000_0009);
    PC = 32'h0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
